adc_capture_ctl: RTL and testbench
==================================

# adc_capture_ctl

Parametrised N-channel capture sequencer for the ADC snapshot buffer. It generalises the one-shot banyan fill into armed capture with pre-trigger depth, decimation, a channel mask, and one-shot, triggered or continuous modes. It sits in the adc_clk domain between the ADC data path and the dual-port capture RAM, and drives the RAM write port and the status readback.

## Interface
- NCH, 8: channel count
- DW, 16: bits per channel sample
- AW, 14: capture RAM address width; depth D = 2^AW
- DSW, 10: decimation counter width

- adc_clk  in  1  sole clock
- adc_rst_n  in  1  reset, synchronous, active-low
- arm  in  1  single-cycle; (re)starts capture, latches config
- abort  in  1  single-cycle; return to IDLE
- sw_trig  in  1  single-cycle software trigger
- ext_trig  in  1  level external trigger; rising edge used
- mode  in  2  0 immediate one-shot, 1 triggered one-shot, 2 continuous, 3 treated as 0
- pretrig  in  AW  pre-trigger sample count P
- decim  in  DSW  keep 1 of (decim+1) valid samples
- chan_mask  in  NCH  1 = channel written, 0 = written as zero
- adc_data  in  NCH*DW  channel n at bits [n*DW +: DW]
- adc_valid  in  1  adc_data valid this cycle
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- wr_data  out  NCH*DW  masked sample
- state  out  3  0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
- full  out  1  capture complete
- trig_ptr  out  AW  address of the trigger sample
- trig_lost  out  1  a trigger arrived in PRE and was ignored; sticky until arm

## Operation
- On arm, latch mode, pretrig, decim and chan_mask. Clear the address counter, the decimation counter, full, trig_lost and any pending trigger.
- Accepted sample: adc_valid=1 while the decimation counter is 0. The counter reloads to decim on each accepted sample and decrements on other valid cycles. Only states PRE, WAIT and POST write. Every accepted sample writes at wr_addr, then wr_addr increments modulo D.
- Trigger event: sw_trig, or a rising edge of ext_trig (previous-cycle register, cleared by reset). The event sets a pending flag, which is consumed by the next accepted sample in WAIT.
- Effective P = min(pretrig, D-1).
- IDLE: no writes. arm leads to PRE for mode 1, to POST for mode 0, and to WAIT for mode 2.
- PRE: after P accepted samples, go to WAIT. P=0 goes straight to WAIT. A trigger in PRE sets trig_lost and is not kept pending.
- WAIT (mode 1): write circularly. An accepted sample with a pending trigger sets trig_ptr to that sample's address and goes to POST; that sample counts as the first post sample.
- POST: write D-P samples in total, counting the trigger sample, then go to DONE with full=1. In mode 0, trig_ptr=0, P is treated as 0, and exactly D samples are written.
- WAIT (mode 2): write forever and ignore triggers; full stays 0.
- DONE: no writes until arm.
- abort in any state goes to IDLE and keeps full and trig_ptr. If arm and abort arrive in the same cycle, arm wins.
- arm mid-capture restarts cleanly from its latched config.

## Timing
- Reset values: state IDLE, all outputs 0.
- wr_en, wr_addr and wr_data are registered one cycle after the adc_data/adc_valid cycle that produced them.
- arm at cycle t: the first write can come from a sample presented at t+1, so wr_en is asserted no earlier than t+2.
- A trigger presented in the same cycle as an accepted sample in WAIT makes that sample the trigger sample.
- state, full and trig_ptr update on the same edge as the last write of a phase. full rises together with the final wr_en.
- Config inputs are ignored except in the arm cycle.

## Test plan
- AW=4, mode 0, decim=0, adc_valid always 1 -> 16 writes at addresses 0..15 on consecutive cycles, then full=1, state=4, trig_ptr=0.
- AW=4, mode 1, P=5, sw_trig 10 samples after PRE ends -> trig_ptr=(5+10)%16=15. Total writes 5+10+11. full asserted on the write at address (15+10)%16=9.
- Mode 1, decim=3, adc_valid toggling every cycle -> only every 4th valid sample is written; the address increments once per 8 cycles.
- Mode 1, ext_trig held high through PRE -> trig_lost=1 and no trigger is taken. A later low-high edge in WAIT triggers normally.
- chan_mask=8'b0000_0101 -> wr_data is nonzero only in channels 0 and 2. Mode 2 run for 40 samples with AW=4 -> wrap with no full. abort -> IDLE, wr_en 0 from the next cycle.
- adc_rst_n low during POST -> next cycle all outputs 0, state IDLE. Simultaneous arm+abort -> capture restarts.

Source files
------------

// File: rtl/adc_capture_ctl.sv
// adc_capture_ctl: armed N-channel capture sequencer feeding the snapshot RAM
// write port. Supports pre-trigger depth, decimation, channel masking and
// immediate one-shot, triggered one-shot or continuous capture.
module adc_capture_ctl #(
  parameter int unsigned NCH = 8,
  parameter int unsigned DW  = 16,
  parameter int unsigned AW  = 14,
  parameter int unsigned DSW = 10
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              sw_trig,
  input  logic              ext_trig,
  input  logic [1:0]        mode,
  input  logic [AW-1:0]     pretrig,
  input  logic [DSW-1:0]    decim,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [NCH*DW-1:0] adc_data,
  input  logic              adc_valid,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [NCH*DW-1:0] wr_data,
  output logic [2:0]        state,
  output logic              full,
  output logic [AW-1:0]     trig_ptr,
  output logic              trig_lost
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    M_ONESHOT = 2'd0,
    M_TRIG    = 2'd1,
    M_CONT    = 2'd2
  } mode_e;

  localparam logic [AW:0]    DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DSW-1:0] DCNT_ONE = {{(DSW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [AW-1:0]     pre_q, pre_d;
  logic [DSW-1:0]    decim_q, decim_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DSW-1:0]    dcnt_q, dcnt_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              lost_q, lost_d;
  logic              pend_q, pend_d;
  logic [AW-1:0]     tptr_q, tptr_d;
  logic              ext_prev_q, ext_prev_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [NCH*DW-1:0] wr_data_q, wr_data_d;

  logic              trig_ev;
  logic              active;
  logic              accept;
  logic [AW:0]       cnt_inc;
  logic [AW:0]       post_total;
  logic [NCH*DW-1:0] masked;
  mode_e             mode_sel;

  // Masked sample: disabled channels are written as zero.
  always_comb begin
    masked = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      masked[n*DW +: DW] = mask_q[n] ? adc_data[n*DW +: DW] : '0;
    end
  end

  // Next-state, capture bookkeeping and RAM write port.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pre_d      = pre_q;
    decim_d    = decim_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    dcnt_d     = dcnt_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    lost_d     = lost_q;
    pend_d     = pend_q;
    tptr_d     = tptr_q;
    ext_prev_d = ext_trig;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    trig_ev    = sw_trig | (ext_trig & ~ext_prev_q);
    active     = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    accept     = active && adc_valid && (dcnt_q == '0);
    cnt_inc    = cnt_q + CNT_ONE;
    // pre_q is AW bits wide, so it never exceeds D-1; no clamp is needed.
    post_total = DEPTH - {1'b0, pre_q};

    case (mode)
      2'd1:    mode_sel = M_TRIG;
      2'd2:    mode_sel = M_CONT;
      default: mode_sel = M_ONESHOT;
    endcase

    if (arm) begin
      // arm takes priority over abort and suppresses this cycle's write.
      mode_d  = mode_sel;
      decim_d = decim;
      mask_d  = chan_mask;
      addr_d  = '0;
      dcnt_d  = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
      lost_d  = 1'b0;
      pend_d  = 1'b0;
      tptr_d  = '0;
      pre_d   = '0;
      case (mode_sel)
        M_TRIG: begin
          pre_d   = pretrig;
          state_d = (pretrig == '0) ? S_WAIT : S_PRE;
        end
        M_CONT:  state_d = S_WAIT;
        default: state_d = S_POST;
      endcase
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      if (active && adc_valid) begin
        dcnt_d = (dcnt_q == '0) ? decim_q : (dcnt_q - DCNT_ONE);
      end
      if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = masked;
        addr_d    = addr_q + ADDR_ONE;
      end
      case (state_q)
        S_PRE: begin
          if (trig_ev) lost_d = 1'b1;
          if (accept) begin
            if (cnt_inc == {1'b0, pre_q}) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_WAIT: begin
          if (mode_q == M_TRIG) begin
            // The trigger sample is the first post sample; with P = D-1 it
            // is also the last one.
            if (accept && (pend_q || trig_ev)) begin
              tptr_d = addr_q;
              pend_d = 1'b0;
              if (post_total == CNT_ONE) begin
                state_d = S_DONE;
                full_d  = 1'b1;
              end else begin
                state_d = S_POST;
                cnt_d   = CNT_ONE;
              end
            end else if (trig_ev) begin
              pend_d = 1'b1;
            end
          end
        end
        S_POST: begin
          if (accept) begin
            if (cnt_inc == post_total) begin
              state_d = S_DONE;
              full_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge adc_clk) begin
    if (!adc_rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_ONESHOT;
      pre_q      <= '0;
      decim_q    <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      dcnt_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      lost_q     <= 1'b0;
      pend_q     <= 1'b0;
      tptr_q     <= '0;
      ext_prev_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pre_q      <= pre_d;
      decim_q    <= decim_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      dcnt_q     <= dcnt_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      lost_q     <= lost_d;
      pend_q     <= pend_d;
      tptr_q     <= tptr_d;
      ext_prev_q <= ext_prev_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign state     = state_q;
  assign full      = full_q;
  assign trig_ptr  = tptr_q;
  assign trig_lost = lost_q;

endmodule

// File: tb/tb_adc_capture_ctl.sv
// Scoreboard bench for adc_capture_ctl with a 16-deep capture RAM.
module tb_adc_capture_ctl;

  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned DSW = 4;

  logic              adc_clk = 1'b0;
  logic              adc_rst_n;
  logic              arm, abort, sw_trig, ext_trig, adc_valid;
  logic [1:0]        mode;
  logic [AW-1:0]     pretrig;
  logic [DSW-1:0]    decim;
  logic [NCH-1:0]    chan_mask;
  logic [NCH*DW-1:0] adc_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic [2:0]        state;
  logic              full;
  logic [AW-1:0]     trig_ptr;
  logic              trig_lost;

  adc_capture_ctl #(.NCH(NCH), .DW(DW), .AW(AW), .DSW(DSW)) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .arm(arm), .abort(abort),
    .sw_trig(sw_trig), .ext_trig(ext_trig), .mode(mode), .pretrig(pretrig),
    .decim(decim), .chan_mask(chan_mask), .adc_data(adc_data),
    .adc_valid(adc_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .state(state), .full(full), .trig_ptr(trig_ptr),
    .trig_lost(trig_lost)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [NCH*DW-1:0] data;
    logic              full;
  } exp_t;

  exp_t           sb[$];
  int unsigned    n_pass  = 0;
  int unsigned    n_total = 0;
  int unsigned    seq     = 0;
  logic [AW-1:0]  ea;
  logic [NCH-1:0] cur_mask;

  function automatic logic [NCH*DW-1:0] pat(input int unsigned s);
    logic [NCH*DW-1:0] r;
    r = '0;
    for (int n = 0; n < NCH; n++) r[n*DW +: DW] = 16'(s * 16 + 32'(n) + 1);
    return r;
  endfunction

  function automatic logic [NCH*DW-1:0] msk(input logic [NCH*DW-1:0] d,
                                            input logic [NCH-1:0] m);
    logic [NCH*DW-1:0] r;
    r = '0;
    for (int n = 0; n < NCH; n++) if (m[n]) r[n*DW +: DW] = d[n*DW +: DW];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle of stimulus; wr queues the expected write for this sample.
  task automatic step(input logic v, input logic st, input logic et,
                      input logic ab, input logic ar, input logic wr, input logic lastf);
    exp_t e;
    adc_valid = v; sw_trig = st; ext_trig = et; abort = ab; arm = ar;
    adc_data  = pat(seq);
    if (wr) begin
      e.addr = ea; e.data = msk(pat(seq), cur_mask); e.full = lastf;
      sb.push_back(e);
      ea = ea + 4'd1;
    end
    seq++;
    @(posedge adc_clk); #1;
  endtask

  // Arm with a config, then scramble the config inputs to show they are latched.
  task automatic do_arm(input logic [1:0] m, input logic [AW-1:0] p,
                        input logic [DSW-1:0] d, input logic [NCH-1:0] cm, input logic ab);
    mode = m; pretrig = p; decim = d; chan_mask = cm;
    cur_mask = cm; ea = '0;
    step(1'b1, 1'b0, 1'b0, ab, 1'b1, 1'b0, 1'b0);
    mode = m + 2'd1; pretrig = ~p; decim = ~d; chan_mask = ~cm;
  endtask

  // Scoreboard monitor: every presented write must match the head of the queue.
  always @(negedge adc_clk) begin
    if (wr_en) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0h expected no write", wr_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        n_total++;
        if (wr_data === e.data) n_pass++;
        else $display("FAIL wr_data@%0h: got %h expected %h", e.addr, wr_data, e.data);
        chk("full_on_write", 32'(full), 32'(e.full));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned acc, vc;
    logic v, t, trig_sent;
    adc_rst_n = 1'b0; arm = 0; abort = 0; sw_trig = 0; ext_trig = 0;
    adc_valid = 0; mode = 0; pretrig = 0; decim = 0; chan_mask = 0;
    adc_data = '0; cur_mask = '1; ea = '0;
    repeat (2) @(posedge adc_clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_full", 32'(full), 0);
    adc_rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);

    // Immediate one-shot: 16 back-to-back writes, full on the last.
    do_arm(2'd0, 4'd0, 4'd0, 8'hFF, 1'b0);
    chk("t1_state_post", 32'(state), 3);
    chk("t1_no_write_arm", 32'(wr_en), 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 1, i == 15);
    chk("t1_state_done", 32'(state), 4);
    chk("t1_full", 32'(full), 1);
    chk("t1_trig_ptr", 32'(trig_ptr), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("t1_done_hold", 32'(state), 4);

    // Triggered one-shot, P=5, trigger 10 samples into WAIT.
    do_arm(2'd1, 4'd5, 4'd0, 8'hFF, 1'b0);
    chk("t2_state_pre", 32'(state), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0);
    chk("t2_state_wait", 32'(state), 2);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 0);
    chk("t2_still_wait", 32'(state), 2);
    step(1, 1, 0, 0, 0, 1, 0);
    chk("t2_state_post", 32'(state), 3);
    chk("t2_trig_ptr", 32'(trig_ptr), 15);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, i == 9);
    chk("t2_state_done", 32'(state), 4);
    chk("t2_full", 32'(full), 1);
    chk("t2_last_addr", 32'(wr_addr), 9);

    // Decimation by 4 with valid every other cycle; pending trigger in WAIT.
    do_arm(2'd1, 4'd14, 4'd3, 8'hFF, 1'b0);
    acc = 0; vc = 0; trig_sent = 0;
    for (int c = 0; c < 200 && acc < 16; c++) begin
      logic a;
      v = (c % 2) == 1;
      t = (acc == 14) && !trig_sent && !v;
      if (t) trig_sent = 1;
      a = v && (vc % 4 == 0);
      if (v) vc++;
      step(v, t, 0, 0, 0, a, a && (acc == 15));
      if (a) acc++;
      if (t) chk("t3_pending_wait", 32'(state), 2);
    end
    chk("t3_accepted", acc, 16);
    chk("t3_state_done", 32'(state), 4);
    chk("t3_trig_ptr", 32'(trig_ptr), 14);
    chk("t3_full", 32'(full), 1);

    // ext_trig high through PRE is lost; a later rising edge triggers.
    do_arm(2'd1, 4'd3, 4'd0, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 1, 0);
    chk("t4_trig_lost", 32'(trig_lost), 1);
    chk("t4_state_wait", 32'(state), 2);
    for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 0, 1, 0);
    chk("t4_level_no_trig", 32'(state), 2);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    chk("t4_state_post", 32'(state), 3);
    chk("t4_trig_ptr", 32'(trig_ptr), 6);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 1, i == 11);
    chk("t4_full", 32'(full), 1);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("t4_abort_idle", 32'(state), 0);
    chk("t4_abort_keep_full", 32'(full), 1);
    chk("t4_abort_keep_ptr", 32'(trig_ptr), 6);
    chk("t4_lost_sticky", 32'(trig_lost), 1);
    step(1, 0, 0, 0, 0, 0, 0);

    // Continuous with channel mask 0 and 2: 40 samples wrap, no full.
    do_arm(2'd2, 4'd7, 4'd0, 8'b0000_0101, 1'b0);
    chk("t5_lost_cleared", 32'(trig_lost), 0);
    for (int i = 0; i < 40; i++) step(1, i == 20, 0, 0, 0, 1, 0);
    chk("t5_state_wait", 32'(state), 2);
    chk("t5_no_full", 32'(full), 0);
    chk("t5_wrap_addr", 32'(wr_addr), 7);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("t5_abort_idle", 32'(state), 0);
    chk("t5_abort_wr_en", 32'(wr_en), 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Mode 3 behaves as mode 0; arm+abort restarts; reset during POST.
    do_arm(2'd3, 4'd5, 4'd0, 8'hFF, 1'b0);
    chk("t6_mode3_post", 32'(state), 3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0);
    do_arm(2'd0, 4'd0, 4'd0, 8'hF0, 1'b1);
    chk("t6_arm_abort_post", 32'(state), 3);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 0);
    adc_rst_n = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t7_rst_state", 32'(state), 0);
    chk("t7_rst_wr_en", 32'(wr_en), 0);
    chk("t7_rst_wr_addr", 32'(wr_addr), 0);
    n_total++;
    if (wr_data === '0) n_pass++;
    else $display("FAIL t7_rst_wr_data: got %h expected 0", wr_data);
    chk("t7_rst_full", 32'(full), 0);
    chk("t7_rst_trig_ptr", 32'(trig_ptr), 0);
    chk("t7_rst_trig_lost", 32'(trig_lost), 0);
    adc_rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
